hs32_bus_arbiter: RTL and testbench
===================================

// Module: hs32_bus_arbiter
// PURPOSE
//  Shares the single MMIO/SRAM slave bus (mmio -> hs32_bram_ctl) between the hs32_cpu
//  master and the Caravel Wishbone slave port. Replaces the static bus_hold mux with
//  registered round-robin arbitration, one outstanding transfer, a slave-ack timeout
//  and flush-safe CPU request handling. Sits between hs32_cpu/Wishbone and mmio.
// PARAMETERS
//  TIMEOUT     255            cycles waiting for i_ack before a forced completion (>=2)
//  TO_DATA     32'hDEAD_BEEF  read data returned to the requester on timeout
// PORTS
//  i_clk        in   1   system clock (wb_clk_i)
//  i_reset_n    in   1   asynchronous active-low reset
//  i_hold       in   1   1: Wishbone owns bus exclusively; CPU requests stay pending
//  i_flush      in   1   CPU pipeline flush; cancels a pending, not-yet-issued CPU request
//  i_cpu_stb    in   1   CPU request, single-cycle pulse
//  i_cpu_rw     in   1   CPU 1=write 0=read
//  i_cpu_addr   in   32  CPU address
//  i_cpu_dtw    in   32  CPU write data
//  o_cpu_dtr    out  32  CPU read data, valid while o_cpu_ack=1
//  o_cpu_ack    out  1   CPU completion, single-cycle pulse
//  i_wb_stb     in   1   Wishbone request level (cyc&stb), held until ack
//  i_wb_rw      in   1   Wishbone 1=write (|sel & we)
//  i_wb_addr    in   32  Wishbone address
//  i_wb_dtw     in   32  Wishbone write data
//  o_wb_dtr     out  32  Wishbone read data, valid while o_wb_ack=1
//  o_wb_ack     out  1   Wishbone ack, single-cycle pulse
//  o_stb        out  1   slave request, single-cycle pulse
//  o_rw,o_addr,o_dtw  out 1/32/32  slave command, held stable from o_stb until i_ack
//  i_dtr        in   32  slave read data, sampled with i_ack
//  i_ack        in   1   slave completion pulse
//  o_busy       out  1   transfer in flight (ram_ce = ~o_busy)
//  o_owner      out  1   current/last grant: 0=CPU 1=WB
//  o_timeout    out  1   sticky: a slave timeout has occurred
// BEHAVIOUR
//  Reset (async, i_reset_n=0): state IDLE; all outputs 0 (o_owner=0, last grant=WB so
//   CPU wins first tie); pending-CPU latch and timeout counter cleared.
//  CPU pulse latched into pend_cpu (cmd captured) on i_cpu_stb; cleared on issue or
//   i_flush in a cycle where pend_cpu is not yet issued. i_cpu_stb with i_flush same
//   cycle: request dropped. i_cpu_stb while pend_cpu=1: ignored (CPU never does this).
//  FSM: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
//   IDLE: candidates = pend_cpu&~i_hold, i_wb_stb&~wb_block. Both: grant the one not
//    granted last. One: grant it. Cmd muxed into o_rw/o_addr/o_dtw registers -> ISSUE.
//   ISSUE: o_stb=1 for exactly 1 cycle, o_busy=1 -> WAIT; timer cleared.
//   WAIT: on i_ack capture i_dtr -> DONE. Timer increments; at TIMEOUT without i_ack:
//    data=TO_DATA, o_timeout<=1 -> DONE. i_ack arriving same cycle as timeout wins.
//   DONE: ack pulse to granted requester with captured data; o_busy=0 -> IDLE.
//  Latency: request visible cycle 0 -> o_stb cycle 1; i_ack cycle n -> requester ack n+1;
//   next grant earliest n+2 (no back-to-back).
//  wb_block: set in DONE for WB, cleared next cycle; prevents regranting the still-held
//   i_wb_stb of the just-acked Wishbone cycle.
//  i_flush during ISSUE/WAIT/DONE with CPU grant: slave transfer completes, o_cpu_ack
//   suppressed (late stale ack never reaches CPU). No effect on WB transfers.
//  i_hold asserted mid-CPU transfer: transfer completes normally; later CPU requests wait.
//  i_wb_stb dropped before grant: request withdrawn, no slave access.
//  o_cpu_dtr/o_wb_dtr hold last captured value; meaningful only with ack.
//  Reset mid-transfer: immediate return to IDLE, acks never issued, pending lost.
// TESTING
//  CPU read 0x100, slave acks 2 cycles after o_stb w/ 0x12345678 -> o_cpu_ack 1 pulse, dtr=0x12345678.
//  CPU pulse + WB level same cycle, reset state -> CPU first, then WB; o_owner 0 then 1.
//  WB write 0x200 held 1 cycle after ack -> exactly one o_stb, one o_wb_ack.
//  i_hold=1, CPU pulse then WB req -> only WB served; drop i_hold -> CPU served next.
//  Slave never acks, TIMEOUT=8 -> ack at o_stb+9 with 0xDEADBEEF, o_timeout=1 stays set.
//  CPU read issued, i_flush in WAIT -> slave completes, o_cpu_ack stays 0, FSM back to IDLE.

Source files
------------

// File: rtl/hs32_bus_arbiter.sv
// hs32_bus_arbiter: registered round-robin arbiter sharing the MMIO/SRAM
// slave bus between the hs32 CPU and the Caravel Wishbone slave port.
//
// Ports:
//   i_clk, i_reset_n           clock, async active-low reset
//   i_hold                     Wishbone owns the bus, CPU requests wait
//   i_flush                    CPU flush: drop pending / in-flight CPU acks
//   i_cpu_*  / o_cpu_*         CPU side (single-cycle stb, single-cycle ack)
//   i_wb_*   / o_wb_*          Wishbone side (level stb, single-cycle ack)
//   o_stb, o_rw, o_addr,
//   o_dtw, i_dtr, i_ack        slave command/response
//   o_busy, o_owner, o_timeout status
//
// One transfer in flight at a time. A slave that never acks is released
// after TIMEOUT wait cycles with TO_DATA as read data.

module hs32_bus_arbiter #(
  parameter int          TIMEOUT = 255,
  parameter logic [31:0] TO_DATA = 32'hDEAD_BEEF
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_hold,
  input  logic        i_flush,
  input  logic        i_cpu_stb,
  input  logic        i_cpu_rw,
  input  logic [31:0] i_cpu_addr,
  input  logic [31:0] i_cpu_dtw,
  output logic [31:0] o_cpu_dtr,
  output logic        o_cpu_ack,
  input  logic        i_wb_stb,
  input  logic        i_wb_rw,
  input  logic [31:0] i_wb_addr,
  input  logic [31:0] i_wb_dtw,
  output logic [31:0] o_wb_dtr,
  output logic        o_wb_ack,
  output logic        o_stb,
  output logic        o_rw,
  output logic [31:0] o_addr,
  output logic [31:0] o_dtw,
  input  logic [31:0] i_dtr,
  input  logic        i_ack,
  output logic        o_busy,
  output logic        o_owner,
  output logic        o_timeout
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  logic [1:0]    state;
  logic [TW-1:0] timer;

  // Latched CPU request (CPU only pulses its strobe)
  logic          pend_cpu;
  logic          pc_rw;
  logic [31:0]   pc_addr;
  logic [31:0]   pc_dtw;

  logic          last_wb;
  logic          wb_block;
  logic          cpu_cancel;

  logic          owner_q;
  logic          rw_q;
  logic [31:0]   addr_q;
  logic [31:0]   dtw_q;
  logic [31:0]   cpu_dtr_q;
  logic [31:0]   wb_dtr_q;
  logic          timeout_q;

  logic          idle;
  logic          cpu_cand;
  logic          wb_cand;
  logic          grant_cpu;
  logic          grant_wb;
  logic          cpu_rw_m;
  logic [31:0]   cpu_addr_m;
  logic [31:0]   cpu_dtw_m;
  logic          timed_out;
  logic [31:0]   rdata;

  assign idle = (state == S_IDLE);

  // A live CPU pulse is a candidate the same cycle so an
  // idle arbiter issues it on the very next cycle.
  assign cpu_cand = (pend_cpu | i_cpu_stb)
                  & ~i_flush & ~i_hold;
  assign wb_cand  = i_wb_stb & ~wb_block;

  // On a tie the side not granted last time wins.
  assign grant_cpu = idle & cpu_cand
                   & (~wb_cand | last_wb);
  assign grant_wb  = idle & wb_cand
                   & (~cpu_cand | ~last_wb);

  assign cpu_rw_m   = pend_cpu ? pc_rw   : i_cpu_rw;
  assign cpu_addr_m = pend_cpu ? pc_addr : i_cpu_addr;
  assign cpu_dtw_m  = pend_cpu ? pc_dtw  : i_cpu_dtw;

  // A real ack in the last wait cycle beats the timeout.
  assign timed_out = (state == S_WAIT) & ~i_ack
                   & (timer == T_LAST);
  assign rdata = i_ack ? i_dtr : TO_DATA;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pend_cpu <= 1'b0;
      pc_rw    <= 1'b0;
      pc_addr  <= '0;
      pc_dtw   <= '0;
    end else if (grant_cpu) begin
      pend_cpu <= 1'b0;
    end else if (i_flush) begin
      pend_cpu <= 1'b0;
    end else if (i_cpu_stb && !pend_cpu) begin
      pend_cpu <= 1'b1;
      pc_rw    <= i_cpu_rw;
      pc_addr  <= i_cpu_addr;
      pc_dtw   <= i_cpu_dtw;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state     <= S_IDLE;
      timer     <= '0;
      owner_q   <= 1'b0;
      last_wb   <= 1'b1;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      dtw_q     <= '0;
      cpu_dtr_q <= '0;
      wb_dtr_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (grant_cpu || grant_wb) begin
            state   <= S_ISSUE;
            owner_q <= grant_wb;
            last_wb <= grant_wb;
            rw_q    <= grant_wb ? i_wb_rw   : cpu_rw_m;
            addr_q  <= grant_wb ? i_wb_addr : cpu_addr_m;
            dtw_q   <= grant_wb ? i_wb_dtw  : cpu_dtw_m;
          end
        end
        S_ISSUE: begin
          state <= S_WAIT;
          timer <= '0;
        end
        S_WAIT: begin
          if (i_ack || timed_out) begin
            state <= S_DONE;
            if (owner_q) begin
              wb_dtr_q <= rdata;
            end else begin
              cpu_dtr_q <= rdata;
            end
            if (timed_out) begin
              timeout_q <= 1'b1;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // A flush while a CPU transfer is in flight kills its ack;
  // the slave side still runs to completion.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cpu_cancel <= 1'b0;
    end else if (grant_cpu || grant_wb) begin
      cpu_cancel <= 1'b0;
    end else if (i_flush && !idle && !owner_q) begin
      cpu_cancel <= 1'b1;
    end
  end

  // Wishbone keeps stb high in the ack cycle and maybe one more;
  // mask it for one cycle so the same cycle is not served twice.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wb_block <= 1'b0;
    end else begin
      wb_block <= (state == S_DONE) & owner_q;
    end
  end

  assign o_stb     = (state == S_ISSUE);
  assign o_busy    = (state == S_ISSUE)
                   | (state == S_WAIT);
  assign o_cpu_ack = (state == S_DONE) & ~owner_q
                   & ~cpu_cancel & ~i_flush;
  assign o_wb_ack  = (state == S_DONE) & owner_q;
  assign o_rw      = rw_q;
  assign o_addr    = addr_q;
  assign o_dtw     = dtw_q;
  assign o_cpu_dtr = cpu_dtr_q;
  assign o_wb_dtr  = wb_dtr_q;
  assign o_owner   = owner_q;
  assign o_timeout = timeout_q;

endmodule

// File: tb/tb_hs32_bus_arbiter.sv
// tb_hs32_bus_arbiter: directed bench for hs32_bus_arbiter
// (cycle table plus hand-written multi-cycle sequences).

module tb_hs32_bus_arbiter;

  logic        clk;
  logic        rst_n;
  logic        hold;
  logic        flush;
  logic        cpu_stb;
  logic        cpu_rw;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_dtw;
  logic [31:0] cpu_dtr;
  logic        cpu_ack;
  logic        wb_stb;
  logic        wb_rw;
  logic [31:0] wb_addr;
  logic [31:0] wb_dtw;
  logic [31:0] wb_dtr;
  logic        wb_ack;
  logic        stb;
  logic        rw;
  logic [31:0] addr;
  logic [31:0] dtw;
  logic [31:0] dtr;
  logic        ack;
  logic        busy;
  logic        owner;
  logic        tmo;

  int checks = 0;
  int errors = 0;

  hs32_bus_arbiter #(
    .TIMEOUT(8),
    .TO_DATA(32'hDEAD_BEEF)
  ) dut (
    .i_clk(clk),
    .i_reset_n(rst_n),
    .i_hold(hold),
    .i_flush(flush),
    .i_cpu_stb(cpu_stb),
    .i_cpu_rw(cpu_rw),
    .i_cpu_addr(cpu_addr),
    .i_cpu_dtw(cpu_dtw),
    .o_cpu_dtr(cpu_dtr),
    .o_cpu_ack(cpu_ack),
    .i_wb_stb(wb_stb),
    .i_wb_rw(wb_rw),
    .i_wb_addr(wb_addr),
    .i_wb_dtw(wb_dtw),
    .o_wb_dtr(wb_dtr),
    .o_wb_ack(wb_ack),
    .o_stb(stb),
    .o_rw(rw),
    .o_addr(addr),
    .o_dtw(dtw),
    .i_dtr(dtr),
    .i_ack(ack),
    .o_busy(busy),
    .o_owner(owner),
    .o_timeout(tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        cs;
    logic [31:0] ca;
    logic        ws;
    logic [31:0] wa;
    logic        ack;
    logic [31:0] dtr;
    logic        e_stb;
    logic        e_busy;
    logic        e_cack;
    logic        e_wack;
    logic        e_own;
    logic [31:0] e_addr;
    logic [31:0] e_data;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(
    input logic [31:0] cs, ca, ws, wa, a, d,
    input logic [31:0] es, eb, ec, ew, eo, ea, ed
  );
    vec_t v;
    v.cs = cs[0]; v.ca = ca;
    v.ws = ws[0]; v.wa = wa;
    v.ack = a[0]; v.dtr = d;
    v.e_stb = es[0]; v.e_busy = eb[0];
    v.e_cack = ec[0]; v.e_wack = ew[0];
    v.e_own = eo[0];
    v.e_addr = ea; v.e_data = ed;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm,
                      input logic act,
                      input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b",
               nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_stb(input string nm);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (stb) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s: o_stb=0 for 8 cycles, expected 1", nm);
    end
  endtask

  task automatic ack_resp(input logic [31:0] d);
    tick();
    ack = 1'b1;
    dtr = d;
    tick();
    ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic observe(input int n,
                         output int ns,
                         output int nc,
                         output int nw);
    ns = 0; nc = 0; nw = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (stb) ns++;
      if (cpu_ack) nc++;
      if (wb_ack) nw++;
      tick();
    end
  endtask

  task automatic cpu_pulse(input logic w,
                           input logic [31:0] a,
                           input logic [31:0] d);
    tick();
    cpu_stb = 1'b1;
    cpu_rw = w;
    cpu_addr = a;
    cpu_dtw = d;
    tick();
    cpu_stb = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int ns, nc, nw, lat;

    rst_n = 1'b0; hold = 1'b0; flush = 1'b0;
    cpu_stb = 1'b0; cpu_rw = 1'b0;
    cpu_addr = '0; cpu_dtw = '0;
    wb_stb = 1'b0; wb_rw = 1'b0;
    wb_addr = '0; wb_dtw = 32'h0000_0200;
    ack = 1'b0; dtr = '0;

    // cs ca ws wa ack dtr | stb busy cack wack own addr data
    tv.push_back(mk(1,'h10, 1,'h200,0,0, 0,0,0,0,0,0,0));
    tv.push_back(mk(0,0, 1,'h200,0,0, 1,1,0,0,0,'h10,0));
    tv.push_back(mk(0,0, 1,'h200,0,0, 0,1,0,0,0,0,0));
    tv.push_back(mk(0,0, 1,'h200,1,'hAAAA0001,
                    0,1,0,0,0,0,0));
    tv.push_back(mk(0,0, 1,'h200,0,0,
                    0,0,1,0,0,0,'hAAAA0001));
    tv.push_back(mk(0,0, 1,'h200,0,0, 0,0,0,0,0,0,0));
    tv.push_back(mk(0,0, 1,'h200,0,0, 1,1,0,0,1,'h200,0));
    tv.push_back(mk(0,0, 1,'h200,1,'h0000CAFE,
                    0,1,0,0,1,0,0));
    tv.push_back(mk(0,0, 1,'h200,0,0,
                    0,0,0,1,1,0,'h0000CAFE));
    tv.push_back(mk(0,0, 1,'h200,0,0, 0,0,0,0,1,0,0));
    tv.push_back(mk(0,0, 0,0,0,0, 0,0,0,0,1,0,0));
    tv.push_back(mk(1,'h100, 0,0,0,0, 0,0,0,0,1,0,0));
    tv.push_back(mk(0,0, 0,0,0,0, 1,1,0,0,0,'h100,0));
    tv.push_back(mk(0,0, 0,0,0,0, 0,1,0,0,0,0,0));
    tv.push_back(mk(0,0, 0,0,1,'h12345678,
                    0,1,0,0,0,0,0));
    tv.push_back(mk(0,0, 0,0,0,0,
                    0,0,1,0,0,0,'h12345678));
    tv.push_back(mk(0,0, 0,0,0,0, 0,0,0,0,0,0,0));

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk1("rst stb", stb, 1'b0);
    chk1("rst busy", busy, 1'b0);
    chk1("rst cpu_ack", cpu_ack, 1'b0);
    chk1("rst wb_ack", wb_ack, 1'b0);
    chk1("rst owner", owner, 1'b0);
    chk1("rst timeout", tmo, 1'b0);
    chk("rst addr", addr, 32'h0);
    rst_n = 1'b1;

    foreach (tv[i]) begin
      tick();
      cpu_stb = tv[i].cs; cpu_rw = 1'b0;
      cpu_addr = tv[i].ca; cpu_dtw = '0;
      wb_stb = tv[i].ws; wb_rw = 1'b1;
      wb_addr = tv[i].wa;
      ack = tv[i].ack; dtr = tv[i].dtr;
      @(negedge clk);
      chk1($sformatf("v%0d stb", i), stb, tv[i].e_stb);
      chk1($sformatf("v%0d busy", i), busy, tv[i].e_busy);
      chk1($sformatf("v%0d cpu_ack", i), cpu_ack, tv[i].e_cack);
      chk1($sformatf("v%0d wb_ack", i), wb_ack, tv[i].e_wack);
      chk1($sformatf("v%0d owner", i), owner, tv[i].e_own);
      if (tv[i].e_stb) begin
        chk($sformatf("v%0d addr", i), addr, tv[i].e_addr);
        chk1($sformatf("v%0d rw", i), rw, tv[i].e_own);
      end
      if (tv[i].e_cack)
        chk($sformatf("v%0d cpu_dtr", i), cpu_dtr, tv[i].e_data);
      if (tv[i].e_wack)
        chk($sformatf("v%0d wb_dtr", i), wb_dtr, tv[i].e_data);
    end

    // hold: pending CPU waits, WB is served
    tick();
    hold = 1'b1;
    cpu_stb = 1'b1; cpu_rw = 1'b1;
    cpu_addr = 32'h300; cpu_dtw = 32'h55;
    tick();
    cpu_stb = 1'b0;
    wb_stb = 1'b1; wb_rw = 1'b0; wb_addr = 32'h400;
    wait_stb("hold wb stb");
    chk("hold wb addr", addr, 32'h400);
    chk1("hold wb owner", owner, 1'b1);
    ack_resp(32'h0BAD_F00D);
    chk1("hold wb ack", wb_ack, 1'b1);
    chk("hold wb dtr", wb_dtr, 32'h0BAD_F00D);
    tick();
    wb_stb = 1'b0;
    observe(5, ns, nc, nw);
    chk("hold cpu blocked", 32'(ns), 32'd0);
    hold = 1'b0;
    wait_stb("unhold cpu stb");
    chk("unhold addr", addr, 32'h300);
    chk1("unhold rw", rw, 1'b1);
    chk("unhold dtw", dtw, 32'h55);
    chk1("unhold owner", owner, 1'b0);
    ack_resp(32'h0);
    chk1("unhold cpu_ack", cpu_ack, 1'b1);

    // slave timeout
    cpu_pulse(1'b0, 32'h500, 32'h0);
    wait_stb("to stb");
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      @(negedge clk);
      if (cpu_ack) begin
        lat = k;
        break;
      end
    end
    chk("to latency", 32'(lat), 32'd9);
    chk("to data", cpu_dtr, 32'hDEAD_BEEF);
    chk1("to flag", tmo, 1'b1);
    tick();
    observe(3, ns, nc, nw);
    chk1("to sticky", tmo, 1'b1);
    chk("to single ack", 32'(nc), 32'd0);

    // flush while waiting on the slave
    cpu_pulse(1'b0, 32'h600, 32'h0);
    wait_stb("fl stb");
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    ack = 1'b1; dtr = 32'h77;
    tick();
    ack = 1'b0;
    observe(4, ns, nc, nw);
    chk("fl cpu_ack suppressed", 32'(nc), 32'd0);
    chk("fl no restb", 32'(ns), 32'd0);
    @(negedge clk);
    chk1("fl idle busy", busy, 1'b0);
    cpu_pulse(1'b0, 32'h610, 32'h0);
    wait_stb("fl next stb");
    ack_resp(32'h1234);
    chk1("fl next ack", cpu_ack, 1'b1);
    chk("fl next dtr", cpu_dtr, 32'h1234);

    // WB request withdrawn before it is granted
    cpu_pulse(1'b0, 32'h800, 32'h0);
    wait_stb("wd stb");
    tick();
    wb_stb = 1'b1; wb_rw = 1'b1; wb_addr = 32'h900;
    tick();
    wb_stb = 1'b0;
    ack = 1'b1; dtr = 32'h88;
    tick();
    ack = 1'b0;
    @(negedge clk);
    chk1("wd cpu_ack", cpu_ack, 1'b1);
    tick();
    observe(5, ns, nc, nw);
    chk("wd no wb stb", 32'(ns), 32'd0);
    chk("wd no wb ack", 32'(nw), 32'd0);

    // flush cancels a pending, not-yet-issued request
    tick();
    hold = 1'b1;
    cpu_stb = 1'b1; cpu_rw = 1'b0; cpu_addr = 32'h700;
    tick();
    cpu_stb = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    hold = 1'b0;
    observe(5, ns, nc, nw);
    chk("pf dropped", 32'(ns), 32'd0);

    // reset mid-transfer
    cpu_pulse(1'b0, 32'hA00, 32'h0);
    wait_stb("rm stb");
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    chk1("rm busy", busy, 1'b0);
    chk1("rm timeout", tmo, 1'b0);
    chk1("rm owner", owner, 1'b0);
    rst_n = 1'b1;
    observe(4, ns, nc, nw);
    chk("rm no ack", 32'(nc), 32'd0);
    chk("rm no stb", 32'(ns), 32'd0);

    // after reset a tie goes to the CPU
    cpu_stb = 1'b1; cpu_addr = 32'hB00;
    wb_stb = 1'b1; wb_addr = 32'hC00;
    tick();
    cpu_stb = 1'b0;
    @(negedge clk);
    chk("rt addr", addr, 32'hB00);
    chk1("rt owner", owner, 1'b0);
    wb_stb = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
